// File: rtl/awgn_stat_monitor_if.sv
// Valid/ready bundle between a Box-Muller AWGN source/consumer and awgn_stat_monitor.
// min_val/max_val exist only when AWGN_STAT_MINMAX_EN is defined.
interface awgn_stat_monitor_if #(
  parameter int LOG2_N = 10
);
  logic                      start;
  logic                      in_valid;
  logic signed [15:0]        x0;
  logic signed [15:0]        x1;
  logic                      busy;
  logic                      res_valid;
  logic                      res_ready;
  logic signed [LOG2_N+16:0] sum;
  logic        [LOG2_N+31:0] sumsq;
  logic        [LOG2_N+1:0]  outlier_cnt;
`ifdef AWGN_STAT_MINMAX_EN
  logic signed [15:0]        min_val;
  logic signed [15:0]        max_val;
`endif

  modport master (
    output start, in_valid, x0, x1, res_ready,
    input  busy, res_valid, sum, sumsq, outlier_cnt
`ifdef AWGN_STAT_MINMAX_EN
    , input min_val, max_val
`endif
  );

  modport slave (
    input  start, in_valid, x0, x1, res_ready,
    output busy, res_valid, sum, sumsq, outlier_cnt
`ifdef AWGN_STAT_MINMAX_EN
    , output min_val, max_val
`endif
  );
endinterface

// File: rtl/awgn_stat_monitor.sv
// Windowed sum / sum-of-squares / outlier statistics over 2^LOG2_N AWGN sample pairs.
// Define AWGN_STAT_MINMAX_EN to add signed min/max tracking of the accepted samples.
module awgn_stat_monitor #(
  parameter int          LOG2_N = 10,
  parameter logic [15:0] THRESH = 16'd6144
) (
  input  logic               clk,
  input  logic               reset,
  awgn_stat_monitor_if.slave bus
);

  localparam int SUM_W = LOG2_N + 17;
  localparam int SQ_W  = LOG2_N + 32;
  localparam int CNT_W = LOG2_N + 2;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, REPORT} state_e;

  state_e              state_q, state_d;
  logic [1:0]          drain_cnt_q;
  logic [LOG2_N-1:0]   pair_cnt_q;
  logic                accept, clear;

  logic                s1_valid_q;
  logic signed [16:0]  s1_sum_q;
  logic        [31:0]  s1_sq_q;
  logic        [1:0]   s1_out_q;

  logic signed [SUM_W-1:0] acc_sum_q;
  logic        [SQ_W-1:0]  acc_sq_q;
  logic        [CNT_W-1:0] acc_out_q;

  logic signed [31:0]  sq0, sq1;
  logic        [16:0]  ext0, ext1, mag0, mag1;
  logic        [1:0]   out_inc;

  assign accept = (state_q == ACCUM) && bus.in_valid;

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    clear   = 1'b0;
    unique case (state_q)
      IDLE: if (bus.start) begin
        state_d = ACCUM;
        clear   = 1'b1;
      end
      ACCUM:  if (accept && (pair_cnt_q == '1)) state_d = DRAIN;
      DRAIN:  if (drain_cnt_q == 2'd2)          state_d = REPORT;
      REPORT: if (bus.res_ready)                state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      drain_cnt_q <= '0;
      pair_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= (state_q == DRAIN) ? drain_cnt_q + 2'd1 : 2'd0;
      if (clear)       pair_cnt_q <= '0;
      else if (accept) pair_cnt_q <= pair_cnt_q + 1'b1;
    end
  end

  // 17-bit magnitude so that |-32768| is 32768 rather than wrapping negative.
  always_comb begin
    sq0     = bus.x0 * bus.x0;
    sq1     = bus.x1 * bus.x1;
    ext0    = {bus.x0[15], bus.x0};
    ext1    = {bus.x1[15], bus.x1};
    mag0    = ext0[16] ? (~ext0 + 17'd1) : ext0;
    mag1    = ext1[16] ? (~ext1 + 17'd1) : ext1;
    out_inc = {1'b0, (mag0 >= {1'b0, THRESH})} + {1'b0, (mag1 >= {1'b0, THRESH})};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_q <= 1'b0;
      s1_sum_q   <= '0;
      s1_sq_q    <= '0;
      s1_out_q   <= '0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_sum_q <= ext0 + ext1;
        s1_sq_q  <= $unsigned(sq0) + $unsigned(sq1);
        s1_out_q <= out_inc;
      end
    end
  end

  // Widths leave room for 2^(LOG2_N+1) worst-case samples, so no overflow is possible.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_sum_q <= '0;
      acc_sq_q  <= '0;
      acc_out_q <= '0;
    end else if (clear) begin
      acc_sum_q <= '0;
      acc_sq_q  <= '0;
      acc_out_q <= '0;
    end else if (s1_valid_q) begin
      acc_sum_q <= acc_sum_q + {{(SUM_W-17){s1_sum_q[16]}}, s1_sum_q};
      acc_sq_q  <= acc_sq_q + {{(SQ_W-32){1'b0}}, s1_sq_q};
      acc_out_q <= acc_out_q + {{(CNT_W-2){1'b0}}, s1_out_q};
    end
  end

`ifdef AWGN_STAT_MINMAX_EN
  logic signed [15:0] s1_min_q, s1_max_q;
  logic signed [15:0] acc_min_q, acc_max_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_min_q  <= '0;
      s1_max_q  <= '0;
      acc_min_q <= '0;
      acc_max_q <= '0;
    end else begin
      if (accept) begin
        s1_min_q <= (bus.x0 < bus.x1) ? bus.x0 : bus.x1;
        s1_max_q <= (bus.x0 > bus.x1) ? bus.x0 : bus.x1;
      end
      if (clear) begin
        acc_min_q <= 16'sh7FFF;
        acc_max_q <= 16'sh8000;
      end else if (s1_valid_q) begin
        if (s1_min_q < acc_min_q) acc_min_q <= s1_min_q;
        if (s1_max_q > acc_max_q) acc_max_q <= s1_max_q;
      end
    end
  end

  assign bus.min_val = acc_min_q;
  assign bus.max_val = acc_max_q;
`endif

  assign bus.busy        = (state_q != IDLE);
  assign bus.res_valid   = (state_q == REPORT);
  assign bus.sum         = acc_sum_q;
  assign bus.sumsq       = acc_sq_q;
  assign bus.outlier_cnt = acc_out_q;

endmodule

// File: tb/tb_awgn_stat_monitor.sv
// Directed bench for awgn_stat_monitor with LOG2_N=2 (4-pair windows), THRESH=6144.
// Inputs change and outputs are sampled on the falling edge.
module tb_awgn_stat_monitor;

  localparam int LOG2_N = 2;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  awgn_stat_monitor_if #(.LOG2_N(LOG2_N)) bus ();

  awgn_stat_monitor #(
    .LOG2_N(LOG2_N),
    .THRESH(16'd6144)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic start_window();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_after_start", longint'(bus.busy), 1);
  endtask

  // Drive one pair per falling edge; in_valid follows the given pattern.
  task automatic send(input logic v, input logic signed [15:0] a, input logic signed [15:0] b);
    bus.in_valid = v;
    bus.x0       = a;
    bus.x1       = b;
    @(negedge clk);
  endtask

  // Returns the number of rising edges after the last accepted pair until res_valid.
  task automatic wait_result(output int lat);
    bus.in_valid = 1'b0;
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      if (bus.res_valid) begin
        lat = i;
        break;
      end
      @(negedge clk);
    end
    if (lat < 0) check("res_valid_timeout", 0, 1);
  endtask

  task automatic handshake();
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    check("res_valid_drop", longint'(bus.res_valid), 0);
    check("busy_drop", longint'(bus.busy), 0);
  endtask

  int lat;

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    reset         = 1'b0;
    bus.start     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.x0        = '0;
    bus.x1        = '0;
    bus.res_ready = 1'b0;

    // Reset held with in_valid toggling
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.in_valid = ~bus.in_valid;
      bus.x0       = 16'sd1234;
      bus.x1       = -16'sd77;
    end
    @(negedge clk);
    check("rst_busy", longint'(bus.busy), 0);
    check("rst_res_valid", longint'(bus.res_valid), 0);
    check("rst_sum", bus.sum, 0);
    check("rst_sumsq", bus.sumsq, 0);
    check("rst_outlier", bus.outlier_cnt, 0);
`ifdef AWGN_STAT_MINMAX_EN
    check("rst_min", bus.min_val, 0);
    check("rst_max", bus.max_val, 0);
`endif
    bus.in_valid = 1'b0;
    reset        = 1'b1;

    // Symmetric constant pairs
    start_window();
    for (int i = 0; i < 4; i++) send(1'b1, 16'sd100, -16'sd100);
    wait_result(lat);
    check("sym_latency", lat, 3);
    check("sym_sum", bus.sum, 0);
    check("sym_sumsq", bus.sumsq, 80000);
    check("sym_outlier", bus.outlier_cnt, 0);
`ifdef AWGN_STAT_MINMAX_EN
    check("sym_min", bus.min_val, -100);
    check("sym_max", bus.max_val, 100);
`endif
    handshake();

    // Extremes
    start_window();
    for (int i = 0; i < 4; i++) send(1'b1, -16'sd32768, 16'sd32767);
    wait_result(lat);
    check("ext_latency", lat, 3);
    check("ext_sum", bus.sum, -4);
    check("ext_sumsq", bus.sumsq, 64'd8589672452);
    check("ext_outlier", bus.outlier_cnt, 8);
`ifdef AWGN_STAT_MINMAX_EN
    check("ext_min", bus.min_val, -32768);
    check("ext_max", bus.max_val, 32767);
`endif
    handshake();

    // Gaps, backpressure, start during REPORT and coincident with the handshake
    start_window();
    send(1'b1, 16'sd6144, 16'sd6144);
    send(1'b0, 16'sd6144, 16'sd6144);
    send(1'b1, 16'sd6144, 16'sd6144);
    send(1'b0, 16'sd6144, 16'sd6144);
    send(1'b0, 16'sd6144, 16'sd6144);
    send(1'b1, 16'sd6144, 16'sd6144);
    send(1'b1, 16'sd6144, 16'sd6144);
    wait_result(lat);
    check("gap_latency", lat, 3);
    check("gap_sum", bus.sum, 49152);
    check("gap_sumsq", bus.sumsq, 301989888);
    check("gap_outlier", bus.outlier_cnt, 8);
    for (int i = 0; i < 5; i++) begin
      bus.start = (i == 2);
      @(negedge clk);
      check("gap_hold_valid", longint'(bus.res_valid), 1);
      check("gap_hold_sum", bus.sum, 49152);
      check("gap_hold_outlier", bus.outlier_cnt, 8);
    end
    bus.start     = 1'b1;
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.start     = 1'b0;
    bus.res_ready = 1'b0;
    check("gap_idle_valid", longint'(bus.res_valid), 0);
    check("gap_idle_busy", longint'(bus.busy), 0);
    @(negedge clk);
    check("gap_start_ignored", longint'(bus.busy), 0);

    // Mid-window reset
    start_window();
    send(1'b1, 16'sd1000, 16'sd1000);
    send(1'b1, 16'sd1000, 16'sd1000);
    bus.in_valid = 1'b0;
    reset        = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", longint'(bus.busy), 0);
    check("mid_rst_sum", bus.sum, 0);
    reset = 1'b1;
    start_window();
    for (int i = 0; i < 4; i++) send(1'b1, 16'sd1, 16'sd2);
    wait_result(lat);
    check("mid_sum", bus.sum, 12);
    check("mid_sumsq", bus.sumsq, 20);
    check("mid_outlier", bus.outlier_cnt, 0);
`ifdef AWGN_STAT_MINMAX_EN
    check("mid_min", bus.min_val, 1);
    check("mid_max", bus.max_val, 2);
`endif
    handshake();

    // Back-to-back window: start the cycle right after the handshake
    start_window();
    for (int i = 0; i < 4; i++) send(1'b1, -16'sd5, 16'sd3);
    wait_result(lat);
    check("b2b_latency", lat, 3);
    check("b2b_sum", bus.sum, -8);
    check("b2b_sumsq", bus.sumsq, 136);
    check("b2b_outlier", bus.outlier_cnt, 0);
`ifdef AWGN_STAT_MINMAX_EN
    check("b2b_min", bus.min_val, -5);
    check("b2b_max", bus.max_val, 3);
`endif
    handshake();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
